// File: rtl/out_alloc_pkg.sv
// out_alloc_pkg: shared widths, FSM encoding and one-hot helper for the switch allocator
package out_alloc_pkg;
    localparam int PORT    = 4;
    localparam int PORT_P1 = 5;
    typedef enum logic {
        OALLOC_IDLE   = 1'b0,
        OALLOC_LOCKED = 1'b1
    } state_t;
    function automatic logic [2:0] oh2idx(input logic [PORT:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i <= PORT; i++)
            idx = oh[i] ? 3'(i) : idx;
        return idx;
    endfunction
endpackage

// File: rtl/out_alloc_if.sv
// out_alloc_if: input-buffer <-> output-allocator handshake
//   req/tail/ready : per-input request, tail marker, downstream credit
//   sel/ack/busy   : registered mux grant, per-input dequeue, output held
interface out_alloc_if;
    import out_alloc_pkg::*;
    logic [PORT:0] req;
    logic [PORT:0] tail;
    logic          ready;
    logic [PORT:0] sel;
    logic [PORT:0] ack;
    logic          busy;
    modport master (output req, tail, ready, input sel, ack, busy);
    modport slave  (input req, tail, ready, output sel, ack, busy);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: 5-way round-robin picker, first requester at or after ptr (wrap 4->0)
//   req/ptr in, gnt one-hot or zero, any = some request present
module rr_pick
    import out_alloc_pkg::*;
(
    input  logic [PORT:0] req,
    input  logic [2:0]    ptr,
    output logic [PORT:0] gnt,
    output logic          any
);
    logic [3:0] j;
    always_comb begin
        gnt = '0;
        j   = '0;
        // Scan farthest to nearest so the port closest to ptr wins last.
        for (int k = PORT; k >= 0; k--) begin
            j = {1'b0, ptr} + 4'(k);
            j = (j >= 4'(PORT_P1)) ? j - 4'(PORT_P1) : j;
            if (req[j[2:0]]) gnt = PORT_P1'(1) << j;
        end
        any = |req;
    end
endmodule

// File: rtl/out_alloc.sv
// out_alloc: per-output switch allocator, holds the grant from head to tail
//   clk, rst_n (async active-low), bus: out_alloc_if.slave
module out_alloc
    import out_alloc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    out_alloc_if.slave   bus
);
    state_t        state, state_nx;
    logic [2:0]    owner, owner_nx, ptr, ptr_nx;
    logic [PORT:0] sel, sel_nx, gnt;
    logic          any, xfer;
    rr_pick u_pick (.req(bus.req), .ptr(ptr), .gnt(gnt), .any(any));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OALLOC_IDLE;
            owner <= '0;
            ptr   <= '0;
            sel   <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            ptr   <= ptr_nx;
            sel   <= sel_nx;
        end
    end
    assign xfer = bus.req[owner] & bus.ready;
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        ptr_nx   = ptr;
        sel_nx   = sel;
        if (state == OALLOC_IDLE) begin
            if (any) begin
                state_nx = OALLOC_LOCKED;
                owner_nx = oh2idx(gnt);
                sel_nx   = gnt;
            end
        end else if (xfer && bus.tail[owner]) begin
            // Pointer moves only on release so a long packet cannot skew fairness.
            state_nx = OALLOC_IDLE;
            sel_nx   = '0;
            ptr_nx   = (owner == 3'(PORT)) ? 3'd0 : owner + 3'd1;
        end
    end
    always_comb begin
        bus.sel  = sel;
        bus.ack  = sel & bus.req & {PORT_P1{bus.ready}};
        bus.busy = (state == OALLOC_LOCKED);
    end
endmodule

// File: tb/tb_out_alloc.sv
// tb_out_alloc: directed self-checking bench for out_alloc
module tb_out_alloc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;
    out_alloc_if bus ();
    out_alloc dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic rd);
        bus.req   = r;
        bus.tail  = t;
        bus.ready = rd;
        #1;
    endtask
    initial begin
        bus.req = '0; bus.tail = '0; bus.ready = 1'b0;
        #2;
        chk("rst_sel", 32'(bus.sel), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_ptr", 32'(dut.ptr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        // single-flit packet on port 2
        tick();
        drive(5'b00100, 5'b00100, 1'b1);
        chk("s_idle_sel", 32'(bus.sel), 0);
        tick();
        chk("s_sel", 32'(bus.sel), 32'b00100);
        chk("s_ack", 32'(bus.ack), 32'b00100);
        chk("s_busy", 32'(bus.busy), 1);
        tick();
        drive(5'b00000, 5'b00000, 1'b1);
        chk("s_rel_sel", 32'(bus.sel), 0);
        chk("s_rel_busy", 32'(bus.busy), 0);
        chk("s_ptr", 32'(dut.ptr), 3);
        // 4-flit packet from port 0 while port 1 waits
        drive(5'b00011, 5'b00000, 1'b1);
        tick();
        for (int c = 1; c <= 4; c++) begin
            drive(5'b00011, (c == 4) ? 5'b00001 : 5'b00000, 1'b1);
            chk("h_sel", 32'(bus.sel), 32'b00001);
            chk("h_ack", 32'(bus.ack), 32'b00001);
            tick();
        end
        drive(5'b00010, 5'b00000, 1'b1);
        chk("h_bubble", 32'(bus.sel), 0);
        chk("h_ptr", 32'(dut.ptr), 1);
        tick();
        drive(5'b00010, 5'b00010, 1'b1);
        chk("h_p1_sel", 32'(bus.sel), 32'b00010);
        chk("h_p1_ack", 32'(bus.ack), 32'b00010);
        tick();
        drive(5'b00000, 5'b00000, 1'b1);
        chk("h_p1_rel", 32'(bus.sel), 0);
        chk("h_p1_ptr", 32'(dut.ptr), 2);
        // round robin from a fresh reset, all single-flit
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(5'b11111, 5'b11111, 1'b1);
        chk("rr_idle", 32'(bus.sel), 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_sel", 32'(bus.sel), 32'(5'b00001 << (k % 5)));
            chk("rr_ack", 32'(bus.ack), 32'(5'b00001 << (k % 5)));
            tick();
            chk("rr_gap", 32'(bus.sel), 0);
            chk("rr_ptr", 32'(dut.ptr), 32'((k + 1) % 5));
        end
        // backpressure on owner 2
        drive(5'b00100, 5'b00000, 1'b1);
        tick();
        chk("bp_sel", 32'(bus.sel), 32'b00100);
        chk("bp_ack", 32'(bus.ack), 32'b00100);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(5'b00100, 5'b00000, 1'b0);
            chk("bp_hold_sel", 32'(bus.sel), 32'b00100);
            chk("bp_hold_ack", 32'(bus.ack), 0);
            chk("bp_hold_busy", 32'(bus.busy), 1);
            chk("bp_hold_ptr", 32'(dut.ptr), 1);
            tick();
        end
        drive(5'b00100, 5'b00100, 1'b1);
        chk("bp_tail_ack", 32'(bus.ack), 32'b00100);
        tick();
        drive(5'b01000, 5'b00000, 1'b1);
        chk("bp_rel", 32'(bus.sel), 0);
        chk("bp_ptr", 32'(dut.ptr), 3);
        // owner 3 bubbles while port 1 requests
        tick();
        chk("ob_sel", 32'(bus.sel), 32'b01000);
        chk("ob_ack", 32'(bus.ack), 32'b01000);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(5'b00010, 5'b00010, 1'b1);
            chk("ob_hold_sel", 32'(bus.sel), 32'b01000);
            chk("ob_hold_ack", 32'(bus.ack), 0);
            tick();
        end
        drive(5'b01010, 5'b01000, 1'b1);
        chk("ob_tail_ack", 32'(bus.ack), 32'b01000);
        tick();
        drive(5'b10000, 5'b00000, 1'b1);
        chk("ob_rel", 32'(bus.sel), 0);
        chk("ob_ptr", 32'(dut.ptr), 4);
        // async reset mid-packet
        tick();
        chk("mr_sel", 32'(bus.sel), 32'b10000);
        chk("mr_busy", 32'(bus.busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_rst_sel", 32'(bus.sel), 0);
        chk("mr_rst_busy", 32'(bus.busy), 0);
        chk("mr_rst_ack", 32'(bus.ack), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr_ptr", 32'(dut.ptr), 0);
        chk("mr_idle_sel", 32'(bus.sel), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
